// File: rtl/mem_arb_pkg.sv
// Shared widths, command encodings and FSM states for the two-master DDR request arbiter.
package mem_arb_pkg;

    localparam int unsigned AF_W   = 31;
    localparam int unsigned WDF_W  = 128;
    localparam int unsigned MASK_W = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        BEAT2_M0,
        BEAT2_M1
    } arb_state_e;

    function automatic logic cmd_valid(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester picker with one-hot grant. MEM_ARB_ROUND_ROBIN_EN selects round-robin
// tie-break against last_grant; otherwise requester 0 has fixed priority.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = req;
        // On a tie, the requester that was not granted last wins.
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges two masters onto one af/wdf FIFO pair, keeping each write's af entry and two beats
// contiguous. MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-break (else master 0 wins ties).
module mem_req_arbiter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_af_wr_en,
    input  logic [AF_W-1:0]     m0_af_addr_din,
    input  logic                m0_wdf_wr_en,
    input  logic [WDF_W-1:0]    m0_wdf_din,
    input  logic [MASK_W-1:0]   m0_wdf_mask_din,
    input  logic                m1_af_wr_en,
    input  logic [AF_W-1:0]     m1_af_addr_din,
    input  logic                m1_wdf_wr_en,
    input  logic [WDF_W-1:0]    m1_wdf_din,
    input  logic [MASK_W-1:0]   m1_wdf_mask_din,
    output logic                m0_af_full,
    output logic                m0_wdf_full,
    output logic                m1_af_full,
    output logic                m1_wdf_full,
    input  logic                af_full,
    input  logic                wdf_full,
    output logic                af_wr_en,
    output logic [AF_W-1:0]     af_addr_din,
    output logic                wdf_wr_en,
    output logic [WDF_W-1:0]    wdf_din,
    output logic [MASK_W-1:0]   wdf_mask_din,
    output logic                proto_err
);

    arb_state_e state_q, state_d;
    logic       proto_err_q;
    logic       last_grant;
    logic [2:0] cmd0, cmd1;
    logic [1:0] pick;
    logic [1:0] af_full_m, wdf_full_m;
    logic       sel_valid, sel, accept, err_set;

    assign cmd0 = m0_af_addr_din[AF_W-1 -: 3];
    assign cmd1 = m1_af_addr_din[AF_W-1 -: 3];

    // Requests with an illegal command never compete for the grant.
    rr_pick2 u_pick (
        .req        ({m1_af_wr_en & cmd_valid(cmd1), m0_af_wr_en & cmd_valid(cmd0)}),
        .last_grant (last_grant),
        .gnt        (pick)
    );

    always_comb begin
        state_d    = state_q;
        af_wr_en   = 1'b0;
        wdf_wr_en  = 1'b0;
        af_full_m  = 2'b11;
        wdf_full_m = 2'b11;
        sel_valid  = 1'b0;
        sel        = 1'b0;
        accept     = 1'b0;
        err_set    = 1'b0;
        if (rst_n) begin
            err_set = (m0_af_wr_en & ~cmd_valid(cmd0)) | (m1_af_wr_en & ~cmd_valid(cmd1));
            case (state_q)
                IDLE: begin
                    err_set = err_set | (m0_wdf_wr_en & ~m0_af_wr_en)
                                      | (m1_wdf_wr_en & ~m1_af_wr_en);
                    if (pick != 2'b00) begin
                        sel_valid = 1'b1;
                        sel       = pick[1];
                        if ((pick[1] ? cmd1 : cmd0) == CMD_WRITE) begin
                            // A write needs room in both FIFOs before beat 1 can go.
                            af_full_m[sel]  = af_full | wdf_full;
                            wdf_full_m[sel] = af_full | wdf_full;
                            if (!af_full && !wdf_full) begin
                                af_wr_en  = 1'b1;
                                wdf_wr_en = 1'b1;
                                accept    = 1'b1;
                                state_d   = pick[1] ? BEAT2_M1 : BEAT2_M0;
                            end
                        end else begin
                            af_full_m[sel]  = af_full;
                            wdf_full_m[sel] = wdf_full;
                            if (!af_full) begin
                                af_wr_en = 1'b1;
                                accept   = 1'b1;
                            end
                        end
                    end
                end
                BEAT2_M0: begin
                    sel_valid     = 1'b1;
                    sel           = 1'b0;
                    af_full_m[0]  = af_full;
                    wdf_full_m[0] = wdf_full;
                    if (m0_wdf_wr_en && !wdf_full) begin
                        wdf_wr_en = 1'b1;
                        state_d   = IDLE;
                    end
                end
                BEAT2_M1: begin
                    sel_valid     = 1'b1;
                    sel           = 1'b1;
                    af_full_m[1]  = af_full;
                    wdf_full_m[1] = wdf_full;
                    if (m1_wdf_wr_en && !wdf_full) begin
                        wdf_wr_en = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m0_af_full  = af_full_m[0];
    assign m1_af_full  = af_full_m[1];
    assign m0_wdf_full = wdf_full_m[0];
    assign m1_wdf_full = wdf_full_m[1];

    assign af_addr_din  = !sel_valid ? '0 : (sel ? m1_af_addr_din  : m0_af_addr_din);
    assign wdf_din      = !sel_valid ? '0 : (sel ? m1_wdf_din      : m0_wdf_din);
    assign wdf_mask_din = !sel_valid ? '0 : (sel ? m1_wdf_mask_din : m0_wdf_mask_din);
    assign proto_err    = proto_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_q | err_set;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Reset to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= sel;
        end
    end

    assign last_grant = last_grant_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign last_grant    = 1'b1;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed test-plan cases plus randomized masters
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_mem_req_arbiter;

    logic         clk;
    logic         rst_n;
    logic         aen [2];
    logic         wen [2];
    logic [30:0]  addr [2];
    logic [127:0] wd [2];
    logic [15:0]  mk [2];
    logic         c_af_full, c_wdf_full;

    logic         m0_af_full, m0_wdf_full, m1_af_full, m1_wdf_full;
    logic         af_wr_en, wdf_wr_en, proto_err;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    mem_req_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_af_wr_en     (aen[0]),
        .m0_af_addr_din  (addr[0]),
        .m0_wdf_wr_en    (wen[0]),
        .m0_wdf_din      (wd[0]),
        .m0_wdf_mask_din (mk[0]),
        .m1_af_wr_en     (aen[1]),
        .m1_af_addr_din  (addr[1]),
        .m1_wdf_wr_en    (wen[1]),
        .m1_wdf_din      (wd[1]),
        .m1_wdf_mask_din (mk[1]),
        .m0_af_full      (m0_af_full),
        .m0_wdf_full     (m0_wdf_full),
        .m1_af_full      (m1_af_full),
        .m1_wdf_full     (m1_wdf_full),
        .af_full         (c_af_full),
        .wdf_full        (c_wdf_full),
        .af_wr_en        (af_wr_en),
        .af_addr_din     (af_addr_din),
        .wdf_wr_en       (wdf_wr_en),
        .wdf_din         (wdf_din),
        .wdf_mask_din    (wdf_mask_din),
        .proto_err       (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: owner = master holding the beat-2 lock (-1 = none), last = last accepted.
    int           owner, last, n_owner, n_last;
    bit           perr, n_err;
    bit           e_af, e_wdf;
    bit           e_maf [2];
    bit           e_mwf [2];
    logic [30:0]  e_addr;
    logic [127:0] e_wd;
    logic [15:0]  e_mk;

    int           mode [2];
    logic [127:0] b2 [2];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_eval();
        int g;
        bit v [2];
        bit space;
        logic [2:0] c;
        g       = -1;
        e_af    = 0;
        e_wdf   = 0;
        n_owner = owner;
        n_last  = last;
        n_err   = 0;
        for (int m = 0; m < 2; m++) begin
            e_maf[m] = 1;
            e_mwf[m] = 1;
            c        = addr[m][30:28];
            v[m]     = aen[m] && (c <= 3'd1);
            if (aen[m] && c > 3'd1) n_err = 1;
        end
        if (owner < 0) begin
            for (int m = 0; m < 2; m++) if (wen[m] && !aen[m]) n_err = 1;
            if (v[0] && v[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                g = 1 - last;
`else
                g = 0;
`endif
            end else if (v[0]) g = 0;
            else if (v[1]) g = 1;
            if (g >= 0) begin
                if (addr[g][30:28] == 3'd0) begin
                    space    = !c_af_full && !c_wdf_full;
                    e_maf[g] = !space;
                    e_mwf[g] = !space;
                    if (space) begin
                        e_af = 1; e_wdf = 1; n_owner = g; n_last = g;
                    end
                end else begin
                    e_maf[g] = c_af_full;
                    e_mwf[g] = c_wdf_full;
                    if (!c_af_full) begin
                        e_af = 1; n_last = g;
                    end
                end
            end
        end else begin
            g        = owner;
            e_maf[g] = c_af_full;
            e_mwf[g] = c_wdf_full;
            if (wen[g] && !c_wdf_full) begin
                e_wdf = 1; n_owner = -1;
            end
        end
        if (g >= 0) begin
            e_addr = addr[g]; e_wd = wd[g]; e_mk = mk[g];
        end else begin
            e_addr = '0; e_wd = '0; e_mk = '0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        check_val("af_wr_en", af_wr_en, e_af);
        check_val("wdf_wr_en", wdf_wr_en, e_wdf);
        check_val("af_addr_din", af_addr_din, e_addr);
        check_val("wdf_din", wdf_din, e_wd);
        check_val("wdf_mask_din", wdf_mask_din, e_mk);
        check_val("m0_af_full", m0_af_full, e_maf[0]);
        check_val("m0_wdf_full", m0_wdf_full, e_mwf[0]);
        check_val("m1_af_full", m1_af_full, e_maf[1]);
        check_val("m1_wdf_full", m1_wdf_full, e_mwf[1]);
        check_val("proto_err", proto_err, perr);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        owner = n_owner;
        last  = n_last;
        perr  = perr | n_err;
    endtask

    task automatic drv(input int m, input logic a, input logic w, input logic [30:0] ad,
                       input logic [127:0] d);
        aen[m]  = a;
        wen[m]  = w;
        addr[m] = ad;
        wd[m]   = d;
        mk[m]   = 16'($urandom);
    endtask

    task automatic idle_all();
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_val("rst_af_wr_en", af_wr_en, 0);
        check_val("rst_wdf_wr_en", wdf_wr_en, 0);
        check_val("rst_m0_af_full", m0_af_full, 1);
        check_val("rst_m0_wdf_full", m0_wdf_full, 1);
        check_val("rst_m1_af_full", m1_af_full, 1);
        check_val("rst_m1_wdf_full", m1_wdf_full, 1);
        check_val("rst_af_addr_din", af_addr_din, 0);
        check_val("rst_wdf_din", wdf_din, 0);
        check_val("rst_proto_err", proto_err, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        owner = -1;
        last  = 1;
        perr  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "time limit reached");
    end

    logic [127:0] d1, d2, e1, e2;

    initial begin
        rst_n      = 1'b1;
        c_af_full  = 1'b0;
        c_wdf_full = 1'b0;
        idle_all();
        // A live request during reset must not leak through.
        drv(1, 1, 1, 31'h0000_0040, rand128());
        #1;
        do_reset();

        // m1 single write to 0x40.
        d1 = rand128(); d2 = rand128();
        drv(1, 1, 1, 31'h0000_0040, d1);
        sample();
        check_val("t1_c0_af", af_wr_en, 1);
        check_val("t1_c0_addr", af_addr_din, 31'h0000_0040);
        check_val("t1_c0_wdf", wdf_wr_en, 1);
        check_val("t1_c0_din", wdf_din, d1);
        advance();
        drv(1, 0, 1, '0, d2);
        sample();
        check_val("t1_c1_wdf", wdf_wr_en, 1);
        check_val("t1_c1_din", wdf_din, d2);
        check_val("t1_c1_af", af_wr_en, 0);
        advance();
        idle_all();
        sample();
        check_val("t1_c2_idle_af", af_wr_en, 0);
        check_val("t1_c2_idle_wdf", wdf_wr_en, 0);
        advance();

        // Simultaneous writes after reset: m0 first, m1 right after m0's beat 2.
        do_reset();
        d1 = rand128(); d2 = rand128(); e1 = rand128(); e2 = rand128();
        drv(0, 1, 1, 31'h0000_1000, d1);
        drv(1, 1, 1, 31'h0000_2000, e1);
        sample();
        check_val("t2_m0_first", af_addr_din, 31'h0000_1000);
        check_val("t2_m1_blocked", m1_af_full, 1);
        advance();
        drv(0, 0, 1, '0, d2);
        sample();
        check_val("t2_m0_beat2", wdf_din, d2);
        check_val("t2_m1_locked_out", m1_af_full, 1);
        advance();
        drv(0, 0, 0, '0, '0);
        sample();
        check_val("t2_m1_granted", af_wr_en, 1);
        check_val("t2_m1_addr", af_addr_din, 31'h0000_2000);
        advance();
        drv(1, 0, 1, '0, e2);
        sample();
        advance();
        idle_all();
        sample();
        advance();

        // Lock to m0 while wdf_full holds for 5 cycles, m1 requesting throughout.
        d1 = rand128(); d2 = rand128(); e1 = rand128(); e2 = rand128();
        drv(0, 1, 1, 31'h0000_0100, d1);
        sample();
        check_val("t3_accept", af_wr_en, 1);
        advance();
        drv(0, 0, 1, '0, d2);
        drv(1, 1, 1, 31'h0000_0200, e1);
        c_wdf_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check_val("t3_lock_wdf", wdf_wr_en, 0);
            check_val("t3_lock_af", af_wr_en, 0);
            check_val("t3_lock_m1_af_full", m1_af_full, 1);
            check_val("t3_lock_m1_wdf_full", m1_wdf_full, 1);
            advance();
        end
        c_wdf_full = 1'b0;
        sample();
        check_val("t3_release_wdf", wdf_wr_en, 1);
        check_val("t3_release_din", wdf_din, d2);
        advance();
        drv(0, 0, 0, '0, '0);
        sample();
        check_val("t3_m1_next", af_addr_din, 31'h0000_0200);
        check_val("t3_m1_next_en", af_wr_en, 1);
        advance();
        drv(1, 0, 1, '0, e2);
        sample();
        advance();
        idle_all();

        // m0 read held off by af_full for 3 cycles.
        drv(0, 1, 0, {3'b001, 28'h0ABCDEF}, rand128());
        c_af_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("t4_rd_held", af_wr_en, 0);
            check_val("t4_rd_m0_af_full", m0_af_full, 1);
            advance();
        end
        c_af_full = 1'b0;
        sample();
        check_val("t4_rd_fwd", af_wr_en, 1);
        check_val("t4_rd_no_wdf", wdf_wr_en, 0);
        check_val("t4_rd_addr", af_addr_din, {3'b001, 28'h0ABCDEF});
        advance();
        idle_all();

        // Randomized protocol-compliant masters against the model.
        do_reset();
        mode[0] = 0;
        mode[1] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            c_af_full  = ($urandom_range(0, 3) == 0);
            c_wdf_full = ($urandom_range(0, 3) == 0);
            for (int m = 0; m < 2; m++) begin
                if (mode[m] == 0) begin
                    case ($urandom_range(0, 5))
                        0, 1: begin
                            mode[m] = 1;
                            b2[m]   = rand128();
                            drv(m, 1, 1, {3'b000, 28'($urandom)}, rand128());
                        end
                        2: begin
                            mode[m] = 3;
                            drv(m, 1, 0, {3'b001, 28'($urandom)}, rand128());
                        end
                        default: drv(m, 0, 0, 31'($urandom), rand128());
                    endcase
                end else if (mode[m] == 2) begin
                    wen[m] = ($urandom_range(0, 3) != 0);
                end
            end
            sample();
            advance();
            for (int m = 0; m < 2; m++) begin
                case (mode[m])
                    1: if (!e_maf[m]) begin
                        mode[m] = 2;
                        aen[m]  = 1'b0;
                        wd[m]   = b2[m];
                    end
                    2: if (wen[m] && !e_mwf[m]) mode[m] = 0;
                    3: if (!e_maf[m]) mode[m] = 0;
                    default: ;
                endcase
            end
        end
        idle_all();
        c_af_full  = 1'b0;
        c_wdf_full = 1'b0;

        // Orphan wdf beat in IDLE: dropped and proto_err sticks until reset.
        do_reset();
        drv(1, 0, 1, '0, rand128());
        sample();
        check_val("t5_orphan_dropped", wdf_wr_en, 0);
        check_val("t5_err_not_yet", proto_err, 0);
        advance();
        idle_all();
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("t5_err_sticky", proto_err, 1);
            advance();
        end
        do_reset();
        drv(0, 1, 0, {3'b101, 28'h5}, rand128());
        sample();
        check_val("t5_badcmd_dropped", af_wr_en, 0);
        advance();
        idle_all();
        sample();
        check_val("t5_badcmd_err", proto_err, 1);
        advance();

        // Reset pulsed while m1 is mid-burst; afterwards m0 wins the tie.
        drv(1, 1, 1, 31'h0000_3000, rand128());
        sample();
        check_val("t6_m1_accept", af_wr_en, 1);
        advance();
        drv(1, 0, 1, '0, rand128());
        drv(0, 1, 1, 31'h0000_4000, rand128());
        do_reset();
        drv(1, 1, 1, 31'h0000_3000, rand128());
        sample();
        check_val("t6_idle_after_rst", af_wr_en, 1);
        check_val("t6_m0_wins", af_addr_din, 31'h0000_4000);
        check_val("t6_m1_blocked", m1_af_full, 1);
        advance();
        drv(0, 0, 1, '0, rand128());
        sample();
        advance();
        drv(0, 0, 0, '0, '0);
        sample();
        check_val("t6_m1_after", af_addr_din, 31'h0000_3000);
        advance();
        drv(1, 0, 1, '0, rand128());
        sample();
        advance();
        idle_all();
        sample();
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
